// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPCR/SPBR/SPSR register bank with baud tick generator and interrupt request.
// Define SPI_MODF_EN to enable mode-fault detection on ss_n_i.
module spi_reg_bank #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [1:0]        addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              xfer_done_i,
    input  logic              dr_access_i,
    input  logic              ss_n_i,
    output logic              spie_o,
    output logic              spe_o,
    output logic              mstr_o,
    output logic              cpol_o,
    output logic              cpha_o,
    output logic              lsbfe_o,
    output logic              sck_tick_o,
    output logic              spi_irq_o
);
    logic [7:0]        spcr_q, spcr_d, spcr_w, spsr;
    logic [DIV_W-1:0]  spbr_q, spbr_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
    logic              spif_q, spif_d, arm_q, arm_d, modf_q, modf_d, modf_arm_q, modf_arm_d;
    logic              rd, spcr_wr, spbr_wr, spsr_rd, run, tick, dr_clr, modf_clr, modf_set;

    assign rd      = rd_en_i & ~wr_en_i;
    assign spcr_wr = wr_en_i & (addr_i == 2'd0);
    assign spbr_wr = wr_en_i & (addr_i == 2'd1);
    assign spsr_rd = rd & (addr_i == 2'd2);
    assign run     = spcr_q[6] & spcr_q[4];
    assign tick    = run & (cnt_q == spbr_q);
    assign dr_clr  = dr_access_i & arm_q;
    assign modf_clr = modf_arm_q & spcr_wr;
    assign spsr    = {spif_q, 2'b00, modf_q, 4'b0000};

`ifdef SPI_MODF_EN
    assign modf_set = run & ~ss_n_i;
`else
    assign modf_set = ss_n_i & 1'b0;
`endif

    assign rd_val = addr_i == 2'd0 ? DATA_W'(spcr_q) :
                    addr_i == 2'd1 ? DATA_W'(spbr_q) :
                    addr_i == 2'd2 ? DATA_W'(spsr) : '0;

    always_comb begin
        spcr_w     = spcr_wr ? (wdata_i[7:0] & 8'hDD) : spcr_q;
        // a mode fault drops SPE and MSTR even against a coincident CPU write
        spcr_d     = modf_set ? (spcr_w & 8'hAF) : spcr_w;
        spbr_d     = spbr_wr ? wdata_i[DIV_W-1:0] : spbr_q;
        cnt_d      = (!run || spbr_wr || tick) ? '0 : cnt_q + DIV_W'(1);
        spif_d     = xfer_done_i | (spif_q & ~dr_clr);
        arm_d      = spcr_q[6] & ~dr_clr & (arm_q | (spsr_rd & spif_q));
        modf_d     = modf_set | (modf_q & ~modf_clr);
        modf_arm_d = ~modf_clr & (modf_arm_q | (spsr_rd & modf_q));
        rdata_d    = rd ? rd_val : rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spcr_q     <= 8'h04;
            spbr_q     <= '0;
            cnt_q      <= '0;
            spif_q     <= 1'b0;
            arm_q      <= 1'b0;
            modf_q     <= 1'b0;
            modf_arm_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            spcr_q     <= spcr_d;
            spbr_q     <= spbr_d;
            cnt_q      <= cnt_d;
            spif_q     <= spif_d;
            arm_q      <= arm_d;
            modf_q     <= modf_d;
            modf_arm_q <= modf_arm_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign spie_o     = spcr_q[7];
    assign spe_o      = spcr_q[6];
    assign mstr_o     = spcr_q[4];
    assign cpol_o     = spcr_q[3];
    assign cpha_o     = spcr_q[2];
    assign lsbfe_o    = spcr_q[0];
    assign sck_tick_o = tick;
    assign spi_irq_o  = spcr_q[7] & (spif_q | modf_q);
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: scoreboard bench for spi_reg_bank; read expectations are queued, a monitor checks rdata.
module tb_spi_reg_bank;
    logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'h00, rdata;
    logic       xfer_done = 1'b0, dr_access = 1'b0, ss_n = 1'b1;
    logic       spie, spe, mstr, cpol, cpha, lsbfe, sck_tick, spi_irq;
    logic [7:0] ov, pat;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] exp_q[$];
    logic [1:0] adr_q[$];

    spi_reg_bank #(.DATA_W(8), .DIV_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .rd_en_i(rd_en), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .xfer_done_i(xfer_done), .dr_access_i(dr_access),
        .ss_n_i(ss_n), .spie_o(spie), .spe_o(spe), .mstr_o(mstr), .cpol_o(cpol),
        .cpha_o(cpha), .lsbfe_o(lsbfe), .sck_tick_o(sck_tick), .spi_irq_o(spi_irq)
    );

    always #5 clk = ~clk;
    assign ov = {spie, spe, mstr, cpol, cpha, lsbfe, sck_tick, spi_irq};

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e);
        rd_en = 1'b1; addr = a;
        exp_q.push_back(e);
        adr_q.push_back(a);
        step();
        rd_en = 1'b0;
    endtask

    task automatic pulse_xd();
        xfer_done = 1'b1; step(); xfer_done = 1'b0;
    endtask

    task automatic pulse_dr();
        dr_access = 1'b1; step(); dr_access = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                logic pend;
                logic [7:0] e;
                logic [1:0] a;
                @(posedge clk);
                pend = rd_en && !wr_en;
                @(negedge clk);
                if (pend) begin
                    if (exp_q.size() == 0) chk("rd_underflow", 8'h01, 8'h00);
                    else begin
                        e = exp_q.pop_front();
                        a = adr_q.pop_front();
                        chk($sformatf("rd_addr%0d", a), rdata, e);
                    end
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("reset_outputs", ov, 8'h08);
                chk("reset_rdata", rdata, 8'h00);
                rst_n = 1'b1;
                rd(2'd0, 8'h04); rd(2'd1, 8'h00); rd(2'd2, 8'h00); rd(2'd3, 8'h00);
                chk("post_reset_outputs", ov, 8'h08);

                wr(2'd1, 8'd3);
                wr(2'd0, 8'h5D);
                chk("spcr_5d_outputs", ov, 8'h7C);
                for (int i = 0; i < 8; i++) begin pat[i] = sck_tick; step(); end
                chk("tick_every_4", pat, 8'h88);
                step(); step();
                wr(2'd1, 8'd3);
                pat = 8'h00;
                for (int i = 0; i < 4; i++) begin pat[i] = sck_tick; step(); end
                chk("spbr_write_restarts", pat, 8'h08);
                rd(2'd1, 8'h03);
                wr(2'd1, 8'd0);
                pat = 8'h00;
                for (int i = 0; i < 3; i++) begin pat[i] = sck_tick; step(); end
                chk("spbr0_every_cycle", pat, 8'h07);
                wr(2'd1, 8'd3);
                rd(2'd0, 8'h5D);
                wr(2'd0, 8'hFF);
                rd(2'd0, 8'hDD);
                chk("irq_idle", {7'd0, spi_irq}, 8'h00);

                pulse_xd();
                chk("irq_on_spif", {7'd0, spi_irq}, 8'h01);
                rd(2'd2, 8'h80);
                pulse_dr();
                rd(2'd2, 8'h00);
                chk("irq_cleared", {7'd0, spi_irq}, 8'h00);
                pulse_xd();
                pulse_dr();
                chk("dr_without_arm", {7'd0, spi_irq}, 8'h01);
                rd(2'd2, 8'h80);
                xfer_done = 1'b1; dr_access = 1'b1;
                step();
                xfer_done = 1'b0; dr_access = 1'b0;
                chk("xfer_coincident_clear", {7'd0, spi_irq}, 8'h01);
                pulse_dr();
                chk("arm_dropped_by_coincident", {7'd0, spi_irq}, 8'h01);
                rd(2'd2, 8'h80);
                pulse_dr();
                rd(2'd2, 8'h00);

                wr_en = 1'b1; rd_en = 1'b1; addr = 2'd1; wdata = 8'd5;
                step();
                wr_en = 1'b0; rd_en = 1'b0;
                chk("wr_rd_rdata_holds", rdata, 8'h00);
                rd(2'd1, 8'h05);
                wr(2'd1, 8'd3);

                wr(2'd0, 8'h50);
                chk("spcr_50_outputs", ov & 8'hFC, 8'h60);
                ss_n = 1'b0;
                step();
                ss_n = 1'b1;
`ifdef SPI_MODF_EN
                chk("modf_spe_mstr", ov & 8'hFC, 8'h00);
                rd(2'd2, 8'h10);
                pat = 8'h00;
                for (int i = 0; i < 4; i++) begin pat[i] = sck_tick; step(); end
                chk("modf_tick_stops", pat, 8'h00);
`else
                chk("modf_spe_mstr", ov & 8'hFC, 8'h60);
                rd(2'd2, 8'h00);
                pat = 8'h00;
                for (int i = 0; i < 4; i++) begin pat[i] = sck_tick; step(); end
                chk("modf_tick_runs", pat, 8'h01);
`endif
                wr(2'd0, 8'h50);
                rd(2'd2, 8'h00);
                chk("spcr_rewrite_outputs", ov & 8'hFC, 8'h60);

                wr(2'd0, 8'hD0);
                pulse_xd();
                rd(2'd2, 8'h80);
                step();
                #3;
                rst_n = 1'b0;
                #1;
                chk("async_reset_outputs", ov, 8'h08);
                chk("async_reset_rdata", rdata, 8'h00);
                step();
                rst_n = 1'b1;
                pulse_dr();
                rd(2'd2, 8'h00);
                rd(2'd0, 8'h04);
                chk("after_reset_outputs", ov, 8'h08);

                step(); step();
                if (exp_q.size() != 0) chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
